// File: rtl/pong_ball_controller.sv
// Pong ball/score sequencer: owns ball position and direction, serve timing,
// scoring and the IDLE/SERVE/PLAY/OVER game state. Advances once per frame_tick.
module pong_ball_controller #(
   parameter int unsigned Y_CEIL      = 10,
   parameter int unsigned Y_FLOOR     = 470,
   parameter int unsigned X_LWALL     = 10,
   parameter int unsigned X_RWALL     = 630,
   parameter int unsigned BALL_W      = 8,
   parameter int unsigned BALL_H      = 8,
   parameter int unsigned PADDLE_W    = 8,
   parameter int unsigned PADDLE_H    = 64,
   parameter int unsigned X_PADDLEA   = 20,
   parameter int unsigned X_PADDLEB   = 612,
   parameter int unsigned X_SERVE     = 316,
   parameter int unsigned Y_SERVE     = 236,
   parameter int unsigned SPEED       = 2,
   parameter int unsigned SERVE_DELAY = 60,
   parameter int unsigned WIN_SCORE   = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       start,
   input  logic [9:0] y_paddleA,
   input  logic [9:0] y_paddleB,
   output logic [9:0] x_ball,
   output logic [9:0] y_ball,
   output logic [3:0] score_a,
   output logic [3:0] score_b,
   output logic       point_a,
   output logic       point_b,
   output logic       game_over,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SERVE = 2'd1,
      ST_PLAY  = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   localparam int unsigned CW = $clog2(SERVE_DELAY + 1);

   localparam logic [10:0] CEIL      = 11'(Y_CEIL);
   localparam logic [10:0] CEIL_LIM  = 11'(Y_CEIL + SPEED);
   localparam logic [10:0] FLOOR_LIM = 11'(Y_FLOOR - BALL_H);
   localparam logic [10:0] LWALL_LIM = 11'(X_LWALL + SPEED);
   localparam logic [10:0] RWALL     = 11'(X_RWALL);
   localparam logic [10:0] BW        = 11'(BALL_W);
   localparam logic [10:0] BH        = 11'(BALL_H);
   localparam logic [10:0] PH        = 11'(PADDLE_H);
   localparam logic [10:0] FACE_A    = 11'(X_PADDLEA + PADDLE_W);
   localparam logic [10:0] FACE_B    = 11'(X_PADDLEB);
   localparam logic [10:0] BOUNCE_XB = 11'(X_PADDLEB - BALL_W);
   localparam logic [10:0] SPD       = 11'(SPEED);
   localparam logic [9:0]  SX        = 10'(X_SERVE);
   localparam logic [9:0]  SY        = 10'(Y_SERVE);
   localparam logic [3:0]  WIN       = 4'(WIN_SCORE);
   localparam logic [CW-1:0] DELAY   = CW'(SERVE_DELAY);

   state_t        state_q, state_d;
   logic [9:0]    x_q, x_d, y_q, y_d;
   logic          dx_q, dx_d, dy_q, dy_d;     // 1 = toward B / downward
   logic [3:0]    score_a_q, score_a_d, score_b_q, score_b_d;
   logic          point_a_q, point_a_d, point_b_q, point_b_d;
   logic          game_over_q, game_over_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [10:0]   x_cur, y_cur, ya, yb, nx, ny;
   logic          ndy, overlap_a, overlap_b, hit_a, hit_b, a_scores, b_scores;

   // Candidate motion for this frame plus bounce, hit and miss detection (11-bit, no wrap)
   always_comb begin
      x_cur = {1'b0, x_q};
      y_cur = {1'b0, y_q};
      ya    = {1'b0, y_paddleA};
      yb    = {1'b0, y_paddleB};

      nx = x_cur;
      if (dx_q) nx = x_cur + SPD;
      else if (x_cur >= SPD) nx = x_cur - SPD;
      else nx = '0;

      ndy = dy_q;
      ny  = y_cur;
      if (!dy_q && (y_cur <= CEIL_LIM)) begin
         ny  = CEIL;
         ndy = 1'b1;
      end else if (dy_q && (y_cur + SPD >= FLOOR_LIM)) begin
         ny  = FLOOR_LIM;
         ndy = 1'b0;
      end else if (dy_q) begin
         ny = y_cur + SPD;
      end else begin
         ny = y_cur - SPD;
      end

      overlap_a = (y_cur + BH > ya) && (y_cur < ya + PH);
      overlap_b = (y_cur + BH > yb) && (y_cur < yb + PH);
      hit_a     = !dx_q && (x_cur >= FACE_A) && (nx <= FACE_A) && overlap_a;
      hit_b     = dx_q && (x_cur + BW <= FACE_B) && (nx + BW >= FACE_B) && overlap_b;
      b_scores  = !dx_q && (x_cur <= LWALL_LIM);
      a_scores  = dx_q && (x_cur + BW + SPD >= RWALL);
   end

   // Game state machine: serve countdown, per-frame ball update, scoring
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      dx_d        = dx_q;
      dy_d        = dy_q;
      score_a_d   = score_a_q;
      score_b_d   = score_b_q;
      point_a_d   = 1'b0;
      point_b_d   = 1'b0;
      cnt_d       = cnt_q;

      unique case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start) begin
               score_a_d = '0;
               score_b_d = '0;
               cnt_d     = DELAY;
               state_d   = ST_SERVE;
            end
         end
         ST_SERVE: begin
            if (frame_tick) begin
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_d = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (frame_tick) begin
               y_d  = 10'(ny);
               dy_d = ndy;
               if (hit_a) begin
                  x_d  = 10'(FACE_A);
                  dx_d = 1'b1;
               end else if (hit_b) begin
                  x_d  = 10'(BOUNCE_XB);
                  dx_d = 1'b0;
               end else if (b_scores || a_scores) begin
                  // Point: ball back to serve, direction toward the conceding side
                  x_d  = SX;
                  y_d  = SY;
                  dx_d = a_scores;
                  if (a_scores) begin
                     score_a_d = score_a_q + 4'd1;
                     point_a_d = 1'b1;
                  end else begin
                     score_b_d = score_b_q + 4'd1;
                     point_b_d = 1'b1;
                  end
                  if ((a_scores && (score_a_q + 4'd1 == WIN)) ||
                      (b_scores && (score_b_q + 4'd1 == WIN))) begin
                     state_d = ST_OVER;
                  end else begin
                     state_d = ST_SERVE;
                     cnt_d   = DELAY;
                  end
               end else begin
                  x_d = 10'(nx);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      game_over_d = (state_d == ST_OVER);
   end

   // State and output registers, asynchronously reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         x_q         <= SX;
         y_q         <= SY;
         dx_q        <= 1'b1;
         dy_q        <= 1'b1;
         score_a_q   <= '0;
         score_b_q   <= '0;
         point_a_q   <= 1'b0;
         point_b_q   <= 1'b0;
         game_over_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         score_a_q   <= score_a_d;
         score_b_q   <= score_b_d;
         point_a_q   <= point_a_d;
         point_b_q   <= point_b_d;
         game_over_q <= game_over_d;
         cnt_q       <= cnt_d;
      end
   end

   assign x_ball    = x_q;
   assign y_ball    = y_q;
   assign score_a   = score_a_q;
   assign score_b   = score_b_q;
   assign point_a   = point_a_q;
   assign point_b   = point_b_q;
   assign game_over = game_over_q;
   assign state     = state_q;

endmodule

// File: tb/tb_pong_ball_controller.sv
// Directed bench for pong_ball_controller: serve timing, wall and paddle
// bounces, scoring, game over and asynchronous reset.
module tb_pong_ball_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       frame_tick;
   logic       start;
   logic [9:0] y_paddleA;
   logic [9:0] y_paddleB;
   logic [9:0] x_ball;
   logic [9:0] y_ball;
   logic [3:0] score_a;
   logic [3:0] score_b;
   logic       point_a;
   logic       point_b;
   logic       game_over;
   logic [1:0] state;

   int tests = 0;
   int fails = 0;

   pong_ball_controller dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .start      (start),
      .y_paddleA  (y_paddleA),
      .y_paddleB  (y_paddleB),
      .x_ball     (x_ball),
      .y_ball     (y_ball),
      .score_a    (score_a),
      .score_b    (score_b),
      .point_a    (point_a),
      .point_b    (point_b),
      .game_over  (game_over),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // One frame tick per call; returns on the negedge after the updating posedge
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         frame_tick = 1'b1;
         @(negedge clk);
         frame_tick = 1'b0;
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, 32'(state), 0);
      chk({tag, "_x"}, 32'(x_ball), 316);
      chk({tag, "_y"}, 32'(y_ball), 236);
      chk({tag, "_sa"}, 32'(score_a), 0);
      chk({tag, "_sb"}, 32'(score_b), 0);
      chk({tag, "_pa"}, 32'(point_a), 0);
      chk({tag, "_pb"}, 32'(point_b), 0);
      chk({tag, "_go"}, 32'(game_over), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b0;
      frame_tick = 1'b0;
      start      = 1'b0;
      y_paddleA  = 10'd1000;
      y_paddleB  = 10'd380;

      // Reset values, and IDLE ignores ticks
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst_n = 1'b1;
      ticks(1);
      chk("idle_tick_state", 32'(state), 0);

      // Serve countdown; start during SERVE must not reload the counter
      pulse_start();
      chk("start_state", 32'(state), 1);
      ticks(29);
      @(negedge clk);
      start = 1'b1;
      frame_tick = 1'b1;
      @(negedge clk);
      start = 1'b0;
      frame_tick = 1'b0;
      ticks(29);
      chk("t59_state", 32'(state), 1);
      chk("t59_x", 32'(x_ball), 316);
      chk("t59_y", 32'(y_ball), 236);
      ticks(1);
      chk("t60_state", 32'(state), 2);
      chk("t60_x", 32'(x_ball), 316);
      chk("t60_y", 32'(y_ball), 236);
      ticks(1);
      chk("k1_x", 32'(x_ball), 318);
      chk("k1_y", 32'(y_ball), 238);

      // Floor bounce at k=113
      ticks(112);
      chk("k113_y", 32'(y_ball), 462);
      chk("k113_x", 32'(x_ball), 542);
      ticks(1);
      chk("k114_y", 32'(y_ball), 460);
      chk("k114_x", 32'(x_ball), 544);

      // Paddle B hit at k=144 (y_paddleB=380)
      ticks(30);
      chk("k144_x", 32'(x_ball), 604);
      chk("k144_y", 32'(y_ball), 400);
      ticks(1);
      chk("k145_x", 32'(x_ball), 602);
      chk("k145_sa", 32'(score_a), 0);
      chk("k145_sb", 32'(score_b), 0);
      chk("k145_state", 32'(state), 2);

      // Miss by B (no overlap): A scores at k=153
      do_reset();
      y_paddleB = 10'd0;
      pulse_start();
      ticks(60 + 152);
      chk("k152_x", 32'(x_ball), 620);
      chk("k152_pa", 32'(point_a), 0);
      ticks(1);
      chk("k153_pa", 32'(point_a), 1);
      chk("k153_sa", 32'(score_a), 1);
      chk("k153_x", 32'(x_ball), 316);
      chk("k153_y", 32'(y_ball), 236);
      chk("k153_state", 32'(state), 1);
      @(negedge clk);
      chk("k153_pa_clear", 32'(point_a), 0);
      y_paddleB = 10'd1000;
      ticks(61);
      chk("srv2_dx_x", 32'(x_ball), 318);
      ticks(152);
      chk("pt2_sa", 32'(score_a), 2);

      // Points 3..9 for A; the ninth ends the game
      for (int p = 3; p <= 9; p++) begin
         ticks(60 + 153);
         chk($sformatf("pt%0d_sa", p), 32'(score_a), 32'(p));
         chk($sformatf("pt%0d_pa", p), 32'(point_a), 1);
         chk($sformatf("pt%0d_state", p), 32'(state), (p == 9) ? 3 : 1);
      end
      chk("over_go", 32'(game_over), 1);
      chk("over_sb", 32'(score_b), 0);
      ticks(5);
      chk("over_hold_state", 32'(state), 3);
      chk("over_hold_x", 32'(x_ball), 316);
      chk("over_hold_y", 32'(y_ball), 236);
      pulse_start();
      chk("restart_state", 32'(state), 1);
      chk("restart_sa", 32'(score_a), 0);
      chk("restart_go", 32'(game_over), 0);

      // Build a 3:2 game from reset, then reset mid-PLAY
      do_reset();
      y_paddleB = 10'd1000;
      pulse_start();
      ticks(3 * (60 + 153));
      chk("g3_sa", 32'(score_a), 3);
      y_paddleB = 10'd40;
      ticks(60 + 144);
      chk("b_hit_x", 32'(x_ball), 604);
      chk("b_hit_y", 32'(y_ball), 72);
      ticks(296);
      chk("b_edge_x", 32'(x_ball), 12);
      chk("b_edge_state", 32'(state), 2);
      ticks(1);
      chk("b1_pb", 32'(point_b), 1);
      chk("b1_sb", 32'(score_b), 1);
      chk("b1_state", 32'(state), 1);
      ticks(60 + 153);
      chk("b2_sb", 32'(score_b), 2);
      chk("b2_sa", 32'(score_a), 3);
      ticks(60 + 10);
      chk("mid_state", 32'(state), 2);
      chk("mid_x", 32'(x_ball), 296);
      chk("mid_y", 32'(y_ball), 256);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async");
      @(negedge clk);
      rst_n = 1'b1;

      // start and tick together: counter still loads the full delay
      @(negedge clk);
      start = 1'b1;
      frame_tick = 1'b1;
      @(negedge clk);
      start = 1'b0;
      frame_tick = 1'b0;
      chk("st_tick_state", 32'(state), 1);
      ticks(59);
      chk("st_tick_59", 32'(state), 1);
      ticks(1);
      chk("st_tick_60", 32'(state), 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pong_ball_controller.md
# pong_ball_controller

Frame-rate game sequencer for Pong. It owns the ball position, ball direction, serve timing and score, and drives the ball coordinates consumed by the display controller. Each frame it advances the ball, bounces it off the ceiling, floor and paddle faces, and detects misses. It also runs the idle / serve / play / game-over state machine. Paddle positions come from the paddle input logic; field geometry is fixed by parameters that must match the display controller.

## Interface
- Y_CEIL, 10: top field boundary; ball y never goes below it.
- Y_FLOOR, 470: bottom field boundary; ball y never exceeds Y_FLOOR-BALL_H.
- X_LWALL, 10: left goal line.
- X_RWALL, 630: right goal line.
- BALL_W / BALL_H, 8 / 8: ball size in pixels.
- PADDLE_W / PADDLE_H, 8 / 64: paddle size in pixels.
- X_PADDLEA, 20: paddle A left x; its front face is X_PADDLEA+PADDLE_W.
- X_PADDLEB, 612: paddle B left x; its front face is X_PADDLEB.
- X_SERVE / Y_SERVE, 316 / 236: ball serve position (top-left corner).
- SPEED, 2: pixels moved per frame on each axis.
- SERVE_DELAY, 60: frames the ball is held before play starts.
- WIN_SCORE, 9: score that ends the game.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse, once per frame, during vblank.
- start  in  1  level/pulse; begins a new game from IDLE or OVER.
- y_paddleA, y_paddleB  in  10 each  paddle top y; must be stable when frame_tick is high.
- x_ball, y_ball  out  10 each  ball top-left corner, registered.
- score_a, score_b  out  4 each  registered point counts.
- point_a, point_b  out  1 each  one-cycle pulse when the named player scores.
- game_over  out  1  high in the OVER state.
- state  out  2  IDLE=0, SERVE=1, PLAY=2, OVER=3.

## Operation
- Reset values: state=IDLE, x_ball=X_SERVE, y_ball=Y_SERVE, dx=+1 (toward B), dy=+1 (down), scores=0, serve counter=0, pulses=0, game_over=0.
- IDLE or OVER, start=1: clear scores, load counter=SERVE_DELAY, go to SERVE. A frame_tick in the same cycle is ignored.
- start is ignored in SERVE and PLAY.
- SERVE: ball is held at the serve position.
  - Each frame_tick decrements the counter.
  - The tick that finds counter==1 moves the state to PLAY.
  - Motion begins on the next tick.
- PLAY, on each frame_tick: compute nx = x ± SPEED and ny = y ± SPEED. All arithmetic is 11-bit unsigned with no wrap; compare as x <= X_LWALL+SPEED rather than subtracting.
- Vertical:
  - dy=-1 and y <= Y_CEIL+SPEED: ny=Y_CEIL, dy=+1.
  - dy=+1 and y+SPEED >= Y_FLOOR-BALL_H: ny=Y_FLOOR-BALL_H, dy=-1.
- Vertical overlap with a paddle, tested on the current y: y+BALL_H > y_paddle and y < y_paddle+PADDLE_H.
- Paddle A hit: dx=-1, x >= X_PADDLEA+PADDLE_W, nx <= X_PADDLEA+PADDLE_W, and overlap with A. Result: nx=X_PADDLEA+PADDLE_W, dx=+1.
- Paddle B hit: dx=+1, x+BALL_W <= X_PADDLEB, nx+BALL_W >= X_PADDLEB, and overlap with B. Result: nx=X_PADDLEB-BALL_W, dx=-1.
- A ball already behind a paddle face never registers a hit.
- Misses are evaluated only if no paddle hit occurred:
  - dx=-1 and x <= X_LWALL+SPEED: B scores.
  - dx=+1 and x+BALL_W+SPEED >= X_RWALL: A scores.
- On a point:
  - Increment the scorer's count and pulse point_x.
  - Return the ball to the serve position; dy is unchanged.
  - Set dx toward the player who conceded.
  - If the new score equals WIN_SCORE, go to OVER. Otherwise go to SERVE with counter=SERVE_DELAY.
- Vertical and horizontal updates apply in the same tick.
- OVER: ball held at the serve position, game_over=1.

## Timing
- All outputs are registered. Position, score and state update on the clk edge that samples frame_tick=1, so they are visible one cycle after the tick.
- point_a/point_b are high for exactly that one cycle.
- frame_tick held high for several cycles is a protocol violation; each high cycle counts as a tick.
- An rst_n assertion at any time, including mid-PLAY, forces the reset values asynchronously.

## Test plan
- Reset, then start, then 59 ticks: state=SERVE, ball at 316,236. Tick 60: state=PLAY, ball still at 316,236. Tick 61: x=318, y=238.
- PLAY ticks k=1..113: y=236+2k, reaching 462 at k=113 (floor). k=114: y=460, x=544.
- y_paddleB=380: at k=144 ball x=604 with dx flipped; k=145 x=602. Score unchanged.
- y_paddleB=0 (no overlap): x reaches 620 at k=152. k=153: point_a pulse, score_a=1, ball at 316,236, dx=+1, state=SERVE.
- Force eight A points, then one more miss by B: score_a=9, state=OVER, game_over=1. start: scores 0, state=SERVE.
- Assert rst_n low mid-PLAY with score 3:2: all outputs at reset values immediately; start plus tick in the same cycle leaves the counter at 60.
